uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Byte FIFO and load sequencer that sits directly upstream of the UART transmitter.
//  Host logic pushes bytes whenever it likes. The block feeds them to the transmitter
//  one at a time over the ld_tx_data / tx_empty handshake, never loading while the
//  transmitter holds data. Shares the transmitter's clock and reset.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of 2, >= 2
//  ADDR_W  4   log2(DEPTH); pointer width (count is ADDR_W+1 bits)
// PORTS
//  txclk        in   1       single clock, all logic on posedge
//  reset        in   1       synchronous, active-high
//  wr_en        in   1       push wr_data this cycle
//  wr_data      in   8       byte to push
//  flush        in   1       drop all queued bytes; clear overflow
//  full         out  1       count == DEPTH
//  fifo_empty   out  1       count == 0
//  count        out  ADDR_W+1  bytes queued (not counting byte handed to UART)
//  overflow     out  1       sticky: push attempted while full
//  ld_tx_data   out  1       one-cycle load strobe to transmitter
//  tx_data      out  8       byte presented with ld_tx_data
//  tx_empty     in   1       transmitter holding register empty
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  Clock/reset: one clock (txclk); reset synchronous, active-high.
//  Reset values: pointers=0, count=0, overflow=0, ld_tx_data=0, tx_data=8'h00, state=IDLE.
//  Reset mid-operation aborts everything; a strobe in flight is deasserted at the same edge.
//  Push: accepted iff wr_en && !full && !flush. mem[wr_ptr]<=wr_data; wr_ptr wraps DEPTH-1->0.
//  Push when full: data dropped; overflow<=1 (held until reset or flush).
//  Pop happens only on the IDLE->LOAD transition. A push and a pop at the same edge leave
//    count unchanged. A push while full is rejected even if a pop occurs at that edge.
//  Flush: wr_ptr=rd_ptr=0, count=0, overflow=0. Flush wins over a same-cycle push
//    (push dropped, no overflow). Flush does not disturb the FSM; a byte already popped
//    completes its handshake.
//  FSM (ld_tx_data and tx_data are registered):
//   IDLE:      if count>0 && tx_empty && !flush -> LOAD; same edge: tx_data<=mem[rd_ptr],
//              ld_tx_data<=1, rd_ptr++, count--.
//   LOAD:      ld_tx_data=1 for exactly this cycle; next edge ld_tx_data<=0 -> WAIT_ACK.
//   WAIT_ACK:  tx_empty==0 -> WAIT_DONE; otherwise stay. The transmitter drops tx_empty at
//              the edge ending LOAD, so this state normally lasts 1 cycle.
//   WAIT_DONE: tx_empty==1 -> IDLE. Waits indefinitely (e.g. tx_enable low downstream).
//  tx_data holds its value outside LOAD; it changes only on a pop.
//  Latency: push at edge N into an empty FIFO with the UART idle -> ld_tx_data high in
//    cycle N+1..N+2 (IDLE sees count>0 after edge N, so the strobe is registered at N+1).
//  Back-to-back bytes: min 3 cycles + UART frame time between strobes. The block never
//    issues a second strobe before tx_empty has gone 0 and returned to 1.
//  Wrap-around: pointers are modulo DEPTH; full and empty are derived from count, never
//    from pointer equality.
// STRUCTURE
//  uart_pkg: BYTE_W=8; enum tx_feed_state_t {IDLE, LOAD, WAIT_ACK, WAIT_DONE}.
//  Sub-module sync_fifo (storage, pointers, count, full/empty, overflow, flush), params
//    DEPTH/ADDR_W/BYTE_W. The FSM and output registers live in uart_tx_fifo.
// TESTING
//  1 Reset, tx_empty=1: push 8'hA5 -> ld_tx_data pulses 1 cycle, tx_data=8'hA5, count 1->0.
//  2 Hold tx_empty=0, push 16 bytes 0..15 -> full=1, count=16, no ld_tx_data;
//    17th push -> overflow=1, count stays 16.
//  3 Model UART (tx_empty low 10 cycles after each load): push 3 bytes -> exactly 3
//    strobes, data 1,2,3 in order, never 2 strobes without tx_empty 0->1 between.
//  4 Fill to DEPTH, drain, refill 5 bytes -> correct order across pointer wrap.
//  5 With count=16: push+pop same edge -> push dropped, overflow=1, count=15.
//    Then flush+push same cycle -> count=0, overflow=0, no strobe follows.
//  6 Assert reset in WAIT_DONE with 4 queued -> next cycle state=IDLE, count=0,
//    ld_tx_data=0, tx_data=8'h00.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
// Byte width and the load-sequencer state encoding.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_ACK,
        WAIT_DONE
    } tx_feed_state_t;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Byte FIFO: storage, modulo pointers, occupancy count, sticky overflow, flush.
// Ports: clk, reset, wr_en/wr_data push, rd_en pop, flush; rd_data, full, empty, count, overflow.
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              flush,
    output logic [BYTE_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push;
    logic              pop;

    assign full    = (count == (ADDR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Full is judged before any same-edge pop, so a push into a full
    // FIFO is dropped even while a byte leaves.
    assign push = wr_en && !full && !flush;
    assign pop  = rd_en && !empty && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus load sequencer feeding the UART transmitter one byte at a time.
// Ports: txclk, reset, wr_en/wr_data/flush in; full, fifo_empty, count, overflow,
// ld_tx_data/tx_data to the transmitter, tx_empty from it, busy while a byte is in flight.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              txclk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              flush,
    output logic              full,
    output logic              fifo_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              ld_tx_data,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_empty,
    output logic              busy
);

    tx_feed_state_t    state;
    tx_feed_state_t    state_n;
    logic              pop;
    logic [BYTE_W-1:0] rd_data;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .BYTE_W (BYTE_W)
    ) u_fifo (
        .clk      (txclk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .flush    (flush),
        .rd_data  (rd_data),
        .full     (full),
        .empty    (fifo_empty),
        .count    (count),
        .overflow (overflow)
    );

    assign busy = (state != IDLE);

    // A byte is only handed over from IDLE, so a second strobe cannot
    // be issued until tx_empty has dropped and returned.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty && tx_empty && !flush) begin
                    pop     = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                state_n = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!tx_empty) begin
                    state_n = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_empty) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge txclk) begin
        if (reset) begin
            state      <= IDLE;
            ld_tx_data <= 1'b0;
            tx_data    <= '0;
        end else begin
            state      <= state_n;
            ld_tx_data <= pop;
            if (pop) begin
                tx_data <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue model, UART model, directed tests.
// Compares every DUT output against the model on each falling edge.
module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic         txclk = 1'b0;
    logic         reset = 1'b1;
    logic         wr_en = 1'b0;
    logic [7:0]   wr_data = 8'h00;
    logic         flush = 1'b0;
    logic         full;
    logic         fifo_empty;
    logic [ADDR_W:0] count;
    logic         overflow;
    logic         ld_tx_data;
    logic [7:0]   tx_data;
    logic         tx_empty;
    logic         busy;

    logic auto_mode = 1'b0;
    logic man_te = 1'b1;
    logic uart_te;
    int   uart_cnt;

    int tests = 0;
    int fails = 0;

    logic [7:0] strobes[$];
    logic hs_ok = 1'b1;
    logic hs_low = 1'b0;

    // Behavioural model state
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_ld = 1'b0;
    logic [7:0] m_txd = 8'h00;
    logic       m_owned = 1'b0;
    logic       m_low = 1'b0;
    logic       m_pop, m_push, m_full;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .txclk      (txclk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .flush      (flush),
        .full       (full),
        .fifo_empty (fifo_empty),
        .count      (count),
        .overflow   (overflow),
        .ld_tx_data (ld_tx_data),
        .tx_data    (tx_data),
        .tx_empty   (tx_empty),
        .busy       (busy)
    );

    always #5 txclk = ~txclk;

    assign tx_empty = auto_mode ? uart_te : man_te;

    // Transmitter: takes the byte at the edge ending the strobe, busy 10 cycles.
    always @(posedge txclk) begin
        if (reset || !auto_mode) begin
            uart_te  <= 1'b1;
            uart_cnt <= 0;
        end else if (ld_tx_data) begin
            uart_te  <= 1'b0;
            uart_cnt <= 10;
        end else if (uart_cnt > 0) begin
            uart_cnt <= uart_cnt - 1;
            if (uart_cnt == 1) uart_te <= 1'b1;
        end
    end

    // Model: bytes in a queue; one byte may be owned by the transmitter
    // from its strobe until tx_empty has been seen low and then high.
    always @(posedge txclk) begin
        if (reset) begin
            q.delete();
            m_ovf   = 1'b0;
            m_ld    = 1'b0;
            m_txd   = 8'h00;
            m_owned = 1'b0;
            m_low   = 1'b0;
        end else begin
            m_full = (q.size() == DEPTH);
            m_pop  = !m_owned && q.size() > 0 && tx_empty && !flush;
            m_push = wr_en && !m_full && !flush;
            if (m_owned) begin
                if (m_ld) m_ld = 1'b0;
                else if (!m_low) begin
                    if (!tx_empty) m_low = 1'b1;
                end else if (tx_empty) m_owned = 1'b0;
            end
            if (flush) begin
                q.delete();
                m_ovf = 1'b0;
            end else begin
                if (wr_en && m_full) m_ovf = 1'b1;
                if (m_pop) begin
                    m_txd   = q.pop_front();
                    m_ld    = 1'b1;
                    m_owned = 1'b1;
                    m_low   = 1'b0;
                end
                if (m_push) q.push_back(wr_data);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge txclk) begin
        chk("ld_tx_data", ld_tx_data, m_ld);
        chk("tx_data", tx_data, m_txd);
        chk("count", count, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("fifo_empty", fifo_empty, q.size() == 0);
        chk("overflow", overflow, m_ovf);
        chk("busy", busy, m_owned);
        if (reset) begin
            hs_ok  = 1'b1;
            hs_low = 1'b0;
        end else if (ld_tx_data) begin
            strobes.push_back(tx_data);
            chk("strobe_gap", hs_ok, 1'b1);
            hs_ok  = 1'b0;
            hs_low = 1'b0;
        end else if (!tx_empty) begin
            hs_low = 1'b1;
        end else if (hs_low) begin
            hs_ok = 1'b1;
        end
    end

    task automatic tick();
        @(negedge txclk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int c = 0;
        while (strobes.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk("strobe_timeout", strobes.size() >= n, 1'b1);
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((busy || !tx_empty) && c < 200) begin
            tick();
            c++;
        end
        chk("idle_timeout", c < 200, 1'b1);
    endtask

    initial begin
        int s0;
        logic [7:0] v;
        tick();
        tick();
        chk("rst_count", count, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_ld", ld_tx_data, 1'b0);
        reset = 1'b0;
        auto_mode = 1'b1;
        tick();

        // 1: single byte, strobe one cycle after the pop decision
        push(8'hA5);
        chk("t1_count1", count, 1);
        chk("t1_no_ld_yet", ld_tx_data, 1'b0);
        tick();
        chk("t1_ld", ld_tx_data, 1'b1);
        chk("t1_data", tx_data, 8'hA5);
        chk("t1_count0", count, 0);
        tick();
        chk("t1_ld_drop", ld_tx_data, 1'b0);
        wait_idle();

        // 2: transmitter held busy, fill and overflow
        auto_mode = 1'b0;
        man_te = 1'b0;
        s0 = strobes.size();
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("t2_full", full, 1'b1);
        chk("t2_count", count, 16);
        chk("t2_no_strobe", strobes.size(), s0);
        push(8'h10);
        chk("t2_ovf", overflow, 1'b1);
        chk("t2_count_hold", count, 16);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t2_flush_count", count, 0);
        chk("t2_flush_ovf", overflow, 1'b0);

        // 3: three bytes through the transmitter model
        auto_mode = 1'b1;
        s0 = strobes.size();
        push(8'h01);
        push(8'h02);
        push(8'h03);
        wait_strobes(s0 + 3, 200);
        wait_idle();
        chk("t3_nstrobes", strobes.size(), s0 + 3);
        for (int i = 0; i < 3; i++) begin
            v = strobes[s0 + i];
            chk("t3_order", v, i + 1);
        end

        // 4: fill, drain, refill across the pointer wrap
        auto_mode = 1'b0;
        man_te = 1'b0;
        s0 = strobes.size();
        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
        chk("t4_full", full, 1'b1);
        auto_mode = 1'b1;
        wait_strobes(s0 + 16, 400);
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
        wait_strobes(s0 + 21, 200);
        wait_idle();
        for (int i = 0; i < 21; i++) begin
            v = strobes[s0 + i];
            chk("t4_order", v, (i < 16) ? 8'h40 + i : 8'h60 + i - 16);
        end

        // 5: push while full at the same edge as a pop, then flush+push
        auto_mode = 1'b0;
        man_te = 1'b0;
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
        chk("t5_count16", count, 16);
        man_te = 1'b1;
        push(8'hEE);
        man_te = 1'b0;
        chk("t5_count15", count, 15);
        chk("t5_ovf", overflow, 1'b1);
        chk("t5_ld", ld_tx_data, 1'b1);
        chk("t5_data", tx_data, 8'h80);
        tick();
        flush = 1'b1;
        push(8'h55);
        flush = 1'b0;
        chk("t5_flush_count", count, 0);
        chk("t5_flush_ovf", overflow, 1'b0);
        s0 = strobes.size();
        man_te = 1'b1;
        repeat (10) tick();
        chk("t5_no_strobe", strobes.size(), s0);
        chk("t5_idle", busy, 1'b0);

        // 6: reset while waiting on the transmitter with 4 queued
        man_te = 1'b0;
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
        man_te = 1'b1;
        tick();
        man_te = 1'b0;
        tick();
        tick();
        chk("t6_busy", busy, 1'b1);
        chk("t6_count4", count, 4);
        reset = 1'b1;
        tick();
        chk("t6_count", count, 0);
        chk("t6_ld", ld_tx_data, 1'b0);
        chk("t6_tx_data", tx_data, 8'h00);
        chk("t6_idle", busy, 1'b0);
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
